// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: width computation, wrap-increment and default thresholds.
package fifo_pkg;

  localparam int unsigned FIFO_AF_MARGIN = 2;
  localparam int unsigned FIFO_AE_MARGIN = 2;

  // Smallest r with 2**r >= n.
  function automatic int unsigned fifo_clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Pointer advance with wrap at an arbitrary depth.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer bus of sync_fifo_flex; master drives requests, slave returns status.
interface sync_fifo_flex_if
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) ();

  localparam int unsigned CNT_W = fifo_clog2(DEPTH + 1);

  logic             clear;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, wr_en, wr_data, rd_en,
    input  rd_data, count, full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  clear, wr_en, wr_data, rd_en,
    output rd_data, count, full, empty, almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock circular FIFO with arbitrary depth, optional FWFT read, thresholds and sticky errors.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - FIFO_AF_MARGIN,
  parameter int unsigned AE_LEVEL = FIFO_AE_MARGIN,
  parameter bit          FWFT     = 1'b0
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_flex_if.slave  bus
);

  localparam int unsigned PTR_W = (fifo_clog2(DEPTH) > 1) ? fifo_clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = fifo_clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flex: DEPTH must be at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_flex: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flex: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic             full_q, empty_q, afull_q, aempty_q, ovf_q, unf_q;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rd;

  // Accept decisions and next occupancy; a read frees room even when full.
  always_comb begin
    wr_acc    = bus.wr_en && !full_q;
    rd_acc    = bus.rd_en && !empty_q;
    count_nxt = count_q;
    if (wr_acc && !rd_acc)      count_nxt = count_q + CNT_W'(1);
    else if (rd_acc && !wr_acc) count_nxt = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), DEPTH));
      if (rd_acc) rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), DEPTH));
      count_q  <= count_nxt;
      full_q   <= (count_nxt == CNT_W'(DEPTH));
      empty_q  <= (count_nxt == '0);
      afull_q  <= (count_nxt >= CNT_W'(AF_LEVEL));
      aempty_q <= (count_nxt <= CNT_W'(AE_LEVEL));
      if (bus.wr_en && full_q)  ovf_q <= 1'b1;
      if (bus.rd_en && empty_q) unf_q <= 1'b1;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc && !bus.clear),
    .wr_addr (wr_ptr),
    .wr_data (bus.wr_data),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd)
  );

  // Read port: head word shown directly in FWFT mode, else captured on each pop.
  if (FWFT) begin : g_fwft
    assign bus.rd_data = empty_q ? '0 : mem_rd;
  end else begin : g_reg
    logic [WIDTH-1:0] rd_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)          rd_q <= '0;
      else if (bus.clear) rd_q <= '0;
      else if (rd_acc)    rd_q <= mem_rd;
    end
    assign bus.rd_data = rd_q;
  end

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised synchronous circular FIFO that supersedes the fixed 16×8 FIFO core for all new single-clock buffering. It adds arbitrary (non-power-of-two) depth, a selectable first-word-fall-through (FWFT) read mode, occupancy output, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a synchronous flush. It sits between any single-clock producer/consumer pair in the datapath.

## Interface
- WIDTH, 8: data word width in bits, ≥1
- DEPTH, 16: number of entries, ≥2, any integer
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1
- FWFT, 0: 0 = registered read, 1 = first-word-fall-through
- Derived localparams: PTR_W = max(1, clog2(DEPTH)); CNT_W = clog2(DEPTH+1)
- Clock and reset: clk, rising edge; reset, asynchronous, active-high.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- clear  in  1  synchronous flush
- wr_en  in  1  write request
- wr_data  in  WIDTH  write data
- rd_en  in  1  read/pop request
- rd_data  out  WIDTH  read data
- count  out  CNT_W  current occupancy, 0..DEPTH
- full, empty, almost_full, almost_empty  out  1 each  status flags
- overflow, underflow  out  1 each  sticky error flags

## Operation
- Write is accepted when wr_en && !full: mem[wr_ptr] ← wr_data, and wr_ptr advances.
- Read is accepted when rd_en && !empty: rd_ptr advances.
- Pointer wrap: a pointer equal to DEPTH-1 goes to 0; otherwise it increments by 1. No power-of-two assumption.
- count: +1 on an accepted write only, −1 on an accepted read only, and unchanged when both are accepted.
- Full with wr_en and rd_en: the read is accepted, the write is dropped, and overflow sets.
- Empty with wr_en and rd_en: the write is accepted, the read is rejected, and underflow sets.
- overflow sets on wr_en && full. underflow sets on rd_en && empty. Both hold until reset or clear.
- Flags are decoded from the next count and registered:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count ≥ AF_LEVEL)
  - almost_empty = (count ≤ AE_LEVEL)
- FWFT=0: on an accepted read, rd_data ← mem[rd_ptr] at that edge. Otherwise rd_data holds its value.
- FWFT=1: rd_data = mem[rd_ptr] combinationally while !empty, and 0 while empty. rd_en pops the displayed word.
- clear takes priority over wr_en and rd_en in the same cycle. Both requests are ignored and no error flag sets. Pointers, count and sticky flags go to 0, flags go to their reset values, and registered rd_data goes to 0. Memory contents are not cleared.
- An illegal AF_LEVEL or AE_LEVEL, or DEPTH < 2, causes an elaboration-time error.

## Timing
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rd_data=0, and pointers=0.
- Asserting reset mid-operation immediately aborts any transfer. Contents are discarded logically.
- Write-to-visible latency:
  - count, empty and the other flags change at the edge that accepts the write.
  - FWFT=1: the word appears on rd_data in the same cycle empty deasserts.
  - FWFT=0: the word appears on rd_data one edge after the accepted read.
- Read latency: FWFT=0 is 1 cycle. FWFT=1 is 0 cycles, and the next word is shown after the popping edge.
- Throughput: one write and one read per cycle sustained, including at full and empty boundaries as defined above.
- All status outputs are registered, so there is no combinational path from wr_en/rd_en to any flag.

## Structure
- Shared package fifo_pkg holds:
  - the wrap-increment function ptr_inc(ptr, depth)
  - default threshold constants FIFO_AF_MARGIN=2 and FIFO_AE_MARGIN=2
  - the clog2 width helper, reused by future FIFO variants
- One sub-module, fifo_mem: a DEPTH×WIDTH array with one synchronous write port and one asynchronous read port. The FWFT=0 output register lives in sync_fifo_flex.
- Control logic (pointers, count, flags, error bits) stays in the top module.

## Test plan
All scenarios use WIDTH=8 and DEPTH=16 unless stated.
- **Reset and fill:** reset, then write 0x00..0x0F with no reads. Expect count 16, full=1 after the 16th write, almost_full=1 after the 14th write, and overflow=0.
- **Overflow and drain:** at full, write 0xAA. Expect it dropped and overflow=1. Then drain 16 words. Expect 0x00..0x0F in order with 1-cycle latency (FWFT=0), empty=1 at the end, and overflow still 1.
- **Simultaneous read/write and wrap:** DEPTH=5, FWFT=1. Preload 3 words, then assert wr_en and rd_en together for 20 cycles with an incrementing pattern. Expect count constant at 3, data in order across multiple pointer wraps, and rd_data valid on the same cycle as the pop.
- **Empty boundary:** when empty, assert wr_en=1 (0x5C) and rd_en=1 together. Expect count 1, underflow=1, and the next read returning 0x5C.
- **Clear priority:** with count 7 and overflow=1, assert clear together with wr_en and rd_en. Expect count 0, empty=1, overflow=0 and underflow=0 next cycle, with no write stored.
- **Reset mid-stream:** assert reset asynchronously while count is 9 and writes are in progress. Expect all outputs at reset values immediately, and a clean refill afterwards.
